// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer
//   Turns the GMII receive byte stream into frame bytes. It strips the
//   preamble, SFD and FCS, checks the CRC-32, the frame length and rx_er,
//   reports each frame's result with a one-cycle pulse, and counts the
//   good and bad frames.
//
// Ports
//   i_clk          GMII receive clock, the only clock
//   i_rst          asynchronous active-high reset
//   i_gmii_rxd     PHY receive data
//   i_gmii_rx_dv   PHY receive data valid
//   i_gmii_rx_er   PHY receive error
//   o_rxdata       frame byte, destination MAC first, FCS stripped
//   o_rx_en        qualifies o_rxdata; high and contiguous for one frame
//   o_frame_ok     pulse: frame ended with good CRC, legal length and no rx_er
//   o_frame_err    pulse: frame ended, or was cut off, with an error
//   o_good_cnt     count of o_frame_ok pulses (wraps)
//   o_bad_cnt      count of o_frame_err pulses (wraps)
module gmii_rx_framer #(
  parameter int MIN_PRE = 1,
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_gmii_rxd,
  input  logic        i_gmii_rx_dv,
  input  logic        i_gmii_rx_er,
  output logic [7:0]  o_rxdata,
  output logic        o_rx_en,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_bad_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  localparam logic [3:0]  LP_MIN_PRE  = 4'(MIN_PRE);
  localparam logic [10:0] LP_MIN_LEN  = 11'(MIN_LEN);
  localparam logic [10:0] LP_MAX_LEN  = 11'(MAX_LEN);
  localparam logic [10:0] LP_MAX_LEN1 = 11'(MAX_LEN + 1);

  // Reflected CRC-32 update (poly 0x04C11DB7 as 0xEDB88320), LSB of each byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ d[i]) == 1'b1) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Bit reversal, so that the reflected register can be compared with the MSB-first residue.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

  logic [7:0]  r_rxd;
  logic        r_dv;
  logic        r_er;
  logic [1:0]  r_state;
  logic [3:0]  r_pre_cnt;
  logic [10:0] r_len;
  logic [31:0] r_crc;
  logic [31:0] r_dly;
  logic        r_err;

  logic [31:0] w_crc_next;
  logic [10:0] w_len_next;
  logic        w_crc_good;
  logic        w_len_ok;

  assign w_crc_next = crc32_byte(r_crc, r_rxd);
  assign w_len_next = r_len + 11'd1;
  // After the data and FCS have passed through, the register holds the fixed residue.
  assign w_crc_good = (bitrev32(r_crc) == 32'hC704_DD7B);
  assign w_len_ok   = (r_len >= LP_MIN_LEN) && (r_len <= LP_MAX_LEN);

  // Input register stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxd <= 8'h00;
      // Reset treats the line as busy. A frame that is still arriving when
      // reset is released therefore goes to DROP instead of being framed.
      r_dv  <= 1'b1;
      r_er  <= 1'b0;
    end else begin
      r_rxd <= i_gmii_rxd;
      r_dv  <= i_gmii_rx_dv;
      r_er  <= i_gmii_rx_er;
    end
  end

  // Framing FSM, FCS delay line, CRC/length tracking and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_pre_cnt   <= 4'd0;
      r_len       <= 11'd0;
      r_crc       <= 32'h0000_0000;
      r_dly       <= 32'h0000_0000;
      r_err       <= 1'b0;
      o_rxdata    <= 8'h00;
      o_rx_en     <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_en     <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_dv) begin
            if (r_rxd == 8'h55) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= 4'd1;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!r_dv) begin
            r_state <= ST_IDLE;
          end else if (r_rxd == 8'h55) begin
            if (r_pre_cnt != 4'd15) begin
              r_pre_cnt <= r_pre_cnt + 4'd1;
            end
          end else if ((r_rxd == 8'hD5) && (r_pre_cnt >= LP_MIN_PRE)) begin
            r_state <= ST_DATA;
            r_len   <= 11'd0;
            r_crc   <= 32'hFFFF_FFFF;
            r_dly   <= 32'h0000_0000;
            r_err   <= 1'b0;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (!r_dv) begin
            r_state <= ST_IDLE;
            if (w_crc_good && w_len_ok && !r_err) begin
              o_frame_ok <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            r_dly <= {r_dly[23:0], r_rxd};
            r_crc <= w_crc_next;
            r_len <= w_len_next;
            if (r_er) begin
              r_err <= 1'b1;
            end
            // Bytes only leave once four newer bytes exist, so the FCS never does.
            if (r_len >= 11'd4) begin
              o_rxdata <= r_dly[31:24];
              o_rx_en  <= 1'b1;
            end
            if (w_len_next == LP_MAX_LEN1) begin
              r_state     <= ST_DROP;
              o_frame_err <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (!r_dv) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Frame counters, which step the cycle after their pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_good_cnt <= 16'd0;
      o_bad_cnt  <= 16'd0;
    end else begin
      if (o_frame_ok) begin
        o_good_cnt <= o_good_cnt + 16'd1;
      end
      if (o_frame_err) begin
        o_bad_cnt <= o_bad_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb_gmii_rx_framer
//   Directed bench for gmii_rx_framer. The bench builds each frame with its
//   own CRC-32. A negedge monitor logs the output bytes and pulses. A table of
//   frame records sets the expected output count, pulses and counters. Some
//   hand-written sequences cover latency, length overflow and reset mid-frame.
module tb_gmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        dv;
  logic        er;
  logic [7:0]  o_rxdata;
  logic        o_rx_en;
  logic        o_frame_ok;
  logic        o_frame_err;
  logic [15:0] o_good_cnt;
  logic [15:0] o_bad_cnt;

  always #4 clk = ~clk;

  gmii_rx_framer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_gmii_rxd   (rxd),
    .i_gmii_rx_dv (dv),
    .i_gmii_rx_er (er),
    .o_rxdata     (o_rxdata),
    .o_rx_en      (o_rx_en),
    .o_frame_ok   (o_frame_ok),
    .o_frame_err  (o_frame_err),
    .o_good_cnt   (o_good_cnt),
    .o_bad_cnt    (o_bad_cnt)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: all of its counters only ever grow.
  logic [7:0] mon_q[$];
  int   mon_ok = 0, mon_err = 0, mon_runs = 0;
  int   mon_first_en = 0, mon_last_en = 0, mon_pulse = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (o_rx_en === 1'b1) begin
      mon_q.push_back(o_rxdata);
      mon_last_en = cyc;
      if (!prev_en) begin
        mon_runs++;
        mon_first_en = cyc;
      end
    end
    if (o_frame_ok === 1'b1) begin
      mon_ok++;
      mon_pulse = cyc;
    end
    if (o_frame_err === 1'b1) begin
      mon_err++;
      mon_pulse = cyc;
    end
    prev_en = (o_rx_en === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  logic [7:0] fr[$];

  task automatic build(input int pay_n, input int flip);
    logic [31:0] c;
    logic [7:0]  b;
    fr.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < pay_n; i++) begin
      b = 8'((i * 37 + 11) ^ (i >> 3));
      fr.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    if (flip != 0) fr[pay_n] = fr[pay_n] ^ 8'h01;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    dv  = v;
    rxd = d;
    er  = e;
  endtask

  // pre_kind 0: pre_n x 0x55 then 0xD5. pre_kind 1: the broken 55 55 54 D5 preamble.
  task automatic send_frame(input int pre_kind, input int pre_n, input int er_at,
                            input int ifg, output int t_first);
    if (pre_kind == 1) begin
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h54, 1'b0);
    end else begin
      for (int i = 0; i < pre_n; i++) drive(1'b1, 8'h55, 1'b0);
    end
    drive(1'b1, 8'hD5, 1'b0);
    t_first = 0;
    for (int i = 0; i < fr.size(); i++) begin
      drive(1'b1, fr[i], (i == er_at));
      if (i == 0) t_first = cyc + 1;  // captured by the DUT's input stage at the next edge
    end
    for (int i = 0; i < ifg; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    int pre_kind;
    int pre_n;
    int pay_n;
    int flip;
    int er_at;
    int exp_nout;
    int exp_ok;
    int exp_err;
  } vec_t;

  vec_t vt[11];

  initial begin
    int t0, b_q, b_ok, b_err, b_runs, mism;
    int exp_good, exp_bad;
    logic [31:0] c;
    logic [7:0]  s[9];

    vt[0]  = '{0, 7,   60, 0, -1,   60, 1, 0};  // good minimum-size frame
    vt[1]  = '{0, 7,   60, 1, -1,   60, 0, 1};  // FCS bit flipped
    vt[2]  = '{1, 0,   60, 0, -1,    0, 0, 0};  // broken preamble
    vt[3]  = '{0, 7,   60, 0, 20,   60, 0, 1};  // rx_er on byte 20
    vt[4]  = '{0, 1,   60, 0, -1,   60, 1, 0};  // single preamble byte
    vt[5]  = '{0, 0,   60, 0, -1,    0, 0, 0};  // SFD with no preamble
    vt[6]  = '{0, 20, 100, 0, -1,  100, 1, 0};  // long preamble, counter saturates
    vt[7]  = '{0, 7,   40, 0, -1,   40, 0, 1};  // runt, 44 bytes
    vt[8]  = '{0, 7,   59, 0, -1,   59, 0, 1};  // 63 bytes, one short
    vt[9]  = '{0, 7, 1514, 0, -1, 1514, 1, 0};  // 1518 bytes, longest legal
    vt[10] = '{0, 7, 1515, 0, -1, 1515, 0, 1};  // 1519 bytes, one too long

    rst = 1'b1;
    dv  = 1'b0;
    rxd = 8'h00;
    er  = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_en", 32'(o_rx_en), 32'd0);
    chk("reset rxdata", 32'(o_rxdata), 32'd0);
    chk("reset frame_ok", 32'(o_frame_ok), 32'd0);
    chk("reset frame_err", 32'(o_frame_err), 32'd0);
    chk("reset good_cnt", 32'(o_good_cnt), 32'd0);
    chk("reset bad_cnt", 32'(o_bad_cnt), 32'd0);
    rst = 1'b0;
    repeat (4) drive(1'b0, 8'h00, 1'b0);

    // Check the bench's CRC against the standard check value for "123456789".
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      s[i] = 8'h31 + 8'(i);
      c = crc_upd(c, s[i]);
    end
    chk("crc model check value", ~c, 32'hCBF4_3926);

    // Good frame: latency and end-of-frame pulse timing.
    build(60, 0);
    b_q = mon_q.size();
    send_frame(0, 7, -1, 12, t0);
    exp_good++;
    chk("latency first byte", 32'(mon_first_en - t0), 32'd5);
    chk("pulse with rx_en drop", 32'(mon_pulse - mon_last_en), 32'd1);
    chk("latency nout", 32'(mon_q.size() - b_q), 32'd60);
    chk("latency good_cnt", 32'(o_good_cnt), 32'(exp_good));

    for (int v = 0; v < 11; v++) begin
      build(vt[v].pay_n, vt[v].flip);
      b_q = mon_q.size(); b_ok = mon_ok; b_err = mon_err; b_runs = mon_runs;
      send_frame(vt[v].pre_kind, vt[v].pre_n, vt[v].er_at, 12, t0);
      exp_good += vt[v].exp_ok;
      exp_bad  += vt[v].exp_err;
      chk($sformatf("v%0d nout", v), 32'(mon_q.size() - b_q), 32'(vt[v].exp_nout));
      mism = 0;
      for (int i = 0; i < vt[v].exp_nout && (b_q + i) < mon_q.size(); i++) begin
        if (mon_q[b_q + i] !== fr[i]) mism++;
      end
      chk($sformatf("v%0d data mismatches", v), 32'(mism), 32'd0);
      chk($sformatf("v%0d frame_ok pulses", v), 32'(mon_ok - b_ok), 32'(vt[v].exp_ok));
      chk($sformatf("v%0d frame_err pulses", v), 32'(mon_err - b_err), 32'(vt[v].exp_err));
      chk($sformatf("v%0d rx_en runs", v), 32'(mon_runs - b_runs), (vt[v].exp_nout > 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d good_cnt", v), 32'(o_good_cnt), 32'(exp_good));
      chk($sformatf("v%0d bad_cnt", v), 32'(o_bad_cnt), 32'(exp_bad));
    end

    // A 1600-byte frame is cut off after 1515 output bytes, then a good frame follows.
    build(1596, 0);
    b_q = mon_q.size(); b_ok = mon_ok; b_err = mon_err;
    send_frame(0, 7, -1, 12, t0);
    exp_bad++;
    chk("long nout", 32'(mon_q.size() - b_q), 32'd1515);
    chk("long frame_err pulses", 32'(mon_err - b_err), 32'd1);
    chk("long frame_ok pulses", 32'(mon_ok - b_ok), 32'd0);
    chk("long bad_cnt", 32'(o_bad_cnt), 32'(exp_bad));
    build(60, 0);
    b_ok = mon_ok;
    send_frame(0, 7, -1, 12, t0);
    exp_good++;
    chk("after long frame_ok", 32'(mon_ok - b_ok), 32'd1);
    chk("after long good_cnt", 32'(o_good_cnt), 32'(exp_good));

    // Reset is pulsed on byte 30 while dv stays high.
    build(60, 0);
    b_ok = mon_ok; b_err = mon_err;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    b_q = mon_q.size();
    for (int i = 0; i < fr.size(); i++) begin
      drive(1'b1, fr[i], 1'b0);
      if (i == 30) begin
        #1;
        chk("rst mid-frame rx_en before", 32'(o_rx_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst mid-frame rx_en async", 32'(o_rx_en), 32'd0);
        chk("rst mid-frame rxdata", 32'(o_rxdata), 32'd0);
        chk("rst mid-frame good_cnt", 32'(o_good_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        b_q = mon_q.size();
      end
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 8'h00, 1'b0);
    chk("rst drop no bytes", 32'(mon_q.size() - b_q), 32'd0);
    chk("rst drop no ok", 32'(mon_ok - b_ok), 32'd0);
    chk("rst drop no err", 32'(mon_err - b_err), 32'd0);
    chk("rst drop bad_cnt", 32'(o_bad_cnt), 32'(exp_bad));
    build(60, 0);
    send_frame(0, 7, -1, 12, t0);
    exp_good++;
    chk("after rst good_cnt", 32'(o_good_cnt), 32'(exp_good));
    chk("after rst bad_cnt", 32'(o_bad_cnt), 32'(exp_bad));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
